// File: rtl/imm_encode_pkg.sv
// Shared immediate-format codes, field MSB positions and the sign-extension test
// used by the immediate extender and the encoder.
package imm_encode_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } enc_state_e;

    localparam int I_MSB = 11;
    localparam int B_MSB = 12;
    localparam int J_MSB = 20;
    localparam int U_MSB = 19;

    // True when every bit above msb is a copy of bit msb.
    function automatic logic sext_ok(input logic [31:0] imm, input int msb);
        logic signed [31:0] t;
        t = $signed(imm) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational immediate packer: scatters imm into the format's instruction
// fields and flags range, alignment or format errors.
module imm_field_pack
    import imm_encode_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [2:0]  immsrc,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        instr = base;
        err   = 1'b0;
        case (immsrc)
            IMM_I: begin
                instr[31:20] = imm[11:0];
                err          = !sext_ok(imm, I_MSB);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                err          = !sext_ok(imm, I_MSB);
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[7]     = imm[11];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                err          = !sext_ok(imm, B_MSB) || imm[0];
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[19:12] = imm[19:12];
                instr[20]    = imm[11];
                instr[30:21] = imm[10:1];
                err          = !sext_ok(imm, J_MSB) || imm[0];
            end
            IMM_U: begin
                instr[31:12] = imm[19:0];
                err          = !sext_ok(imm, U_MSB);
            end
            // Illegal format: base passes through untouched.
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// Immediate encoder with a single-entry output register and saturating
// delivered/error word counters.
//
// state    | meaning
// ST_EMPTY | no word held, out_valid=0, input always accepted
// ST_FULL  | word held in out_instr/out_err, out_valid=1
module imm_encode
    import imm_encode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_immsrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    enc_state_e  state;
    logic [31:0] pack_instr;
    logic        pack_err;
    logic        in_xfer;
    logic        out_xfer;

    imm_field_pack u_pack (
        .base   (in_base),
        .imm    (in_imm),
        .immsrc (in_immsrc),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    assign out_valid = (state == ST_FULL);
    assign in_ready  = (state == ST_EMPTY) || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            out_instr <= '0;
            out_err   <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (in_xfer) begin
                state     <= ST_FULL;
                out_instr <= pack_instr;
                out_err   <= pack_err;
            end else if (out_xfer) begin
                state <= ST_EMPTY;
            end
            if (out_xfer) begin
                if (enc_count != '1)
                    enc_count <= enc_count + CNT_W'(1);
                if (out_err && (err_count != '1))
                    err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: expected words are queued on acceptance and
// checked as they leave the output register.
module tb_imm_encode;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_base = '0;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_immsrc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int   total = 0;
    int   bad = 0;
    bit   rnd_ready = 1'b0;
    exp_t exp_q[$];

    imm_encode #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .in_immsrc (in_immsrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] b, input logic [31:0] imm, input logic [2:0] src);
        exp_t e;
        int   si;
        si = $signed(imm);
        case (src)
            3'd0: begin
                e.instr = (b & 32'h000FFFFF) | {imm[11:0], 20'h0};
                e.err   = (si < -2048) || (si > 2047);
            end
            3'd1: begin
                e.instr = (b & 32'h01FFF07F) | {imm[11:5], 13'h0, imm[4:0], 7'h0};
                e.err   = (si < -2048) || (si > 2047);
            end
            3'd2: begin
                e.instr = (b & 32'h01FFF07F) | {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
                e.err   = (si < -4096) || (si > 4094) || imm[0];
            end
            3'd3: begin
                e.instr = (b & 32'h00000FFF) | {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
                e.err   = (si < -1048576) || (si > 1048574) || imm[0];
            end
            3'd4: begin
                e.instr = (b & 32'h00000FFF) | {imm[19:0], 12'h0};
                e.err   = (si < -524288) || (si > 524287);
            end
            default: begin
                e.instr = b;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] b, input logic [31:0] imm, input logic [2:0] src,
                        input logic [31:0] ei, input logic ee);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        e.instr = ei;
        e.err   = ee;
        in_valid  = 1'b1;
        in_base   = b;
        in_imm    = imm;
        in_immsrc = src;
        for (int n = 0; n < 60; n++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_m(input logic [31:0] b, input logic [31:0] imm, input logic [2:0] src);
        exp_t e;
        e = model(b, imm, src);
        send(b, imm, src, e.instr, e.err);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: owns the expected counter values.
    initial begin : mon
        int e_enc;
        int e_err;
        exp_t e;
        e_enc = 0;
        e_err = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                e_enc = 0;
                e_err = 0;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", out_instr, e.instr);
                    chk("err", {31'd0, out_err}, {31'd0, e.err});
                    chk("enc_count", {16'd0, enc_count}, e_enc);
                    chk("err_count", {16'd0, err_count}, e_err);
                    e_enc++;
                    if (e.err) e_err++;
                end
            end
        end
    end

    initial begin : main
        logic [31:0] b, imm;
        logic [2:0]  src;
        logic [31:0] held;

        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_enc", {16'd0, enc_count}, 32'd0);
        chk("rst_err", {16'd0, err_count}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors.
        out_ready = 1'b1;
        send(32'h00000313, 32'h00000001, 3'b000, 32'h00100313, 1'b0);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("enc_after_i", {16'd0, enc_count}, 32'd1);
        send(32'h00000063, 32'hFFFFFFF8, 3'b010, 32'hFE000CE3, 1'b0);
        send(32'h0000006F, 32'h00000008, 3'b011, 32'h0080006F, 1'b0);
        send(32'h0000006F, 32'h00000009, 3'b011, 32'h0080006F, 1'b1);
        send(32'h00000313, 32'h00000800, 3'b000, 32'h80000313, 1'b1);
        send(32'h00000313, 32'h00000800, 3'b111, 32'h00000313, 1'b1);
        drain();
        chk("enc_directed", {16'd0, enc_count}, 32'd6);
        chk("err_directed", {16'd0, err_count}, 32'd3);

        // Backpressure: second request stalls while first word is held.
        do_reset();
        out_ready = 1'b0;
        send(32'h00000013, 32'h0000007F, 3'b000, 32'h07F00013, 1'b0);
        in_valid  = 1'b1;
        in_base   = 32'h00000023;
        in_imm    = 32'hFFFFFFFF;
        in_immsrc = 3'b001;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", out_instr, 32'h07F00013);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back('{instr: 32'hFE000FA3, err: 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        chk("bp_enc", {16'd0, enc_count}, 32'd2);

        // Random traffic with random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            b   = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 3) != 0) imm = $signed(imm) >>> $urandom_range(10, 30);
            if ($urandom_range(0, 1) != 0) imm[0] = 1'b0;
            src = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            send_m(b, imm, src);
        end
        rnd_ready = 1'b0;
        drain();

        // Reset while a word is held: it must vanish without being counted.
        out_ready = 1'b0;
        send_m(32'h00000093, 32'h00000005, 3'b000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_enc", {16'd0, enc_count}, 32'd0);
        chk("mid_rst_err", {16'd0, err_count}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("post_rst_enc", {16'd0, enc_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
